// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone field widths, arbiter state encodings and a one-hot helper
// used by the wb_arbiter slice.
package wb_arbiter_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam int WB_TIMEOUT_DEFAULT = 255;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // One-hot (up to 8 masters) to binary index; zero when nothing is set.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// ptr (with wrap) wins, reported one-hot.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: one owner per cyc tenure, with a
// watchdog that terminates stalled strobes with err.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = WB_TIMEOUT_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [ADR_W*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [DAT_W*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [SEL_W*NUM_MASTERS-1:0]   m_sel_i,
    output logic [DAT_W-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_err_o,
    output logic [NUM_MASTERS-1:0]         m_rty_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [ADR_W-1:0]               s_adr_o,
    output logic [DAT_W-1:0]               s_dat_o,
    output logic [SEL_W-1:0]               s_sel_o,
    input  logic [DAT_W-1:0]               s_dat_i,
    input  logic                           s_ack_i,
    input  logic                           s_err_i,
    input  logic                           s_rty_i,
    output logic [NUM_MASTERS-1:0]         grant_o
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);

    logic [0:0]             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       next_ptr;
    logic [2:0]             pick_idx;
    logic [CNT_W-1:0]       wd_cnt;

    logic                   own_cyc;
    logic                   own_stb;
    logic                   own_we;
    logic [ADR_W-1:0]       own_adr;
    logic [DAT_W-1:0]       own_dat;
    logic [SEL_W-1:0]       own_sel;
    logic                   slave_term;
    logic                   wd_fire;

    rr_pick #(
        .N  (NUM_MASTERS),
        .PW (PTR_W)
    ) u_rr_pick (
        .req   (m_cyc_i),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = oh2idx(8'(pick_gnt));
        if (pick_idx == 3'(NUM_MASTERS - 1)) next_ptr = '0;
        else                                 next_ptr = PTR_W'(pick_idx + 3'd1);
    end

    // grant is all-zero outside BUSY, so the owner mux alone idles the slave side.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant[k]) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_adr = m_adr_i[k*ADR_W +: ADR_W];
                own_dat = m_dat_i[k*DAT_W +: DAT_W];
                own_sel = m_sel_i[k*SEL_W +: SEL_W];
            end
        end
    end

    assign slave_term = s_ack_i | s_err_i | s_rty_i;
    // A real slave termination on the timeout cycle suppresses the injected err.
    assign wd_fire    = WD_EN && (state == ST_BUSY) && (wd_cnt == CNT_W'(TIMEOUT))
                        && own_cyc && own_stb && !slave_term;

    assign s_cyc_o = own_cyc;
    assign s_stb_o = own_stb & ~wd_fire;
    assign s_we_o  = own_we;
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant & {NUM_MASTERS{s_ack_i}};
    assign m_err_o = grant & {NUM_MASTERS{s_err_i | wd_fire}};
    assign m_rty_o = grant & {NUM_MASTERS{s_rty_i}};
    assign grant_o = grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (state == ST_IDLE) begin
            if (pick_valid) begin
                state  <= ST_BUSY;
                grant  <= pick_gnt;
                rr_ptr <= next_ptr;
            end
        end else if (!own_cyc) begin
            state <= ST_IDLE;
            grant <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (!WD_EN || state != ST_BUSY || !own_cyc || !s_stb_o || slave_term) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (2 masters, TIMEOUT=4): vector table, directed
// corner-case sequences, and random traffic against a reference model.
module tb_wb_arbiter;

    localparam int NM = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [32*NM-1:0] m_adr_i, m_dat_i;
    logic [4*NM-1:0]  m_sel_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]       s_sel_o;
    logic             s_ack_i, s_err_i, s_rty_i;

    wb_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner index (-1 = free), next priority index, stall age.
    int mdl_owner, mdl_ptr, mdl_wait;
    logic [NM-1:0] e_grant, e_ack, e_err, e_rty;
    logic          e_cyc, e_stb, e_we;
    logic [31:0]   e_adr, e_dat;
    logic [3:0]    e_sel;

    task automatic mdl_reset();
        mdl_owner = -1;
        mdl_ptr   = 0;
        mdl_wait  = 0;
    endtask

    task automatic mdl_eval();
        int  o;
        bit  term, fire;
        e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        if (mdl_owner >= 0) begin
            o    = mdl_owner;
            term = s_ack_i || s_err_i || s_rty_i;
            fire = (mdl_wait == TO) && m_cyc_i[o] && m_stb_i[o] && !term;
            e_grant[o] = 1'b1;
            e_cyc = m_cyc_i[o];
            e_stb = m_stb_i[o] && !fire;
            e_we  = m_we_i[o];
            e_adr = m_adr_i[o*32 +: 32];
            e_dat = m_dat_i[o*32 +: 32];
            e_sel = m_sel_i[o*4 +: 4];
            e_ack[o] = s_ack_i;
            e_err[o] = s_err_i || fire;
            e_rty[o] = s_rty_i;
        end
    endtask

    task automatic mdl_advance();
        int o;
        if (mdl_owner < 0) begin
            mdl_wait = 0;
            for (int i = 0; i < NM; i++) begin
                o = (mdl_ptr + i) % NM;
                if (m_cyc_i[o]) begin
                    mdl_owner = o;
                    mdl_ptr   = (o + 1) % NM;
                    break;
                end
            end
        end else begin
            o = mdl_owner;
            if (!m_cyc_i[o] || !e_stb || s_ack_i || s_err_i || s_rty_i) mdl_wait = 0;
            else mdl_wait++;
            if (!m_cyc_i[o]) mdl_owner = -1;
        end
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = {32'h200, 32'h100};
        m_dat_i = {32'hBBBB_0001, 32'hAAAA_0000};
        m_sel_i = 8'hF3;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        s_dat_i = 32'h1234_5678;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n   = 1'b0;
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_F00D;
        #3;
        check("rst_grant", grant_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_s_stb", s_stb_o, 1'b0);
        check("rst_s_adr", s_adr_o, 32'h0);
        check("rst_m_ack", m_ack_o, 2'b00);
        check("rst_m_dat", m_dat_o, 32'hCAFE_F00D);
        s_ack_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_reset();
    endtask

    typedef struct {
        logic [1:0] cyc, stb;
        logic       ack, err;
        logic [1:0] x_grant;
        logic       x_cyc, x_stb;
        logic [1:0] x_ack, x_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x_adr;
        int          n;
        bit          found;

        //            cyc    stb    ack   err   grant  scyc  sstb  mack   merr
        vecs[0]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00};
        vecs[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00};
        vecs[7]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[8]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[9]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01};
        vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};

        // Vector table: single master tenure, then master 1 then master 0.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            m_cyc_i = vecs[r].cyc;
            m_stb_i = vecs[r].stb;
            s_ack_i = vecs[r].ack;
            s_err_i = vecs[r].err;
            #4;
            x_adr = (vecs[r].x_grant == 2'b01) ? 32'h100 :
                    (vecs[r].x_grant == 2'b10) ? 32'h200 : 32'h0;
            check($sformatf("vec%0d_grant", r), grant_o, vecs[r].x_grant);
            check($sformatf("vec%0d_s_cyc", r), s_cyc_o, vecs[r].x_cyc);
            check($sformatf("vec%0d_s_stb", r), s_stb_o, vecs[r].x_stb);
            check($sformatf("vec%0d_m_ack", r), m_ack_o, vecs[r].x_ack);
            check($sformatf("vec%0d_m_err", r), m_err_o, vecs[r].x_err);
            check($sformatf("vec%0d_s_adr", r), s_adr_o, x_adr);
            tick();
        end

        // Simultaneous requests from reset: master 0 first, master 1 two cycles after release.
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick();
        #4;
        check("both_first_grant", grant_o, 2'b01);
        tick();
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        n = 0; found = 0;
        while (!found && n < 10) begin
            tick();
            n++;
            #4;
            if (grant_o == 2'b10) found = 1;
        end
        check("release_to_grant_latency", n, 2);

        // Fairness under continuous requests.
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b00;
        for (int t = 0; t < 6; t++) begin
            found = 0; n = 0;
            while (!found && n < 10) begin
                #4;
                if (grant_o != 2'b00) found = 1;
                else begin tick(); n++; end
            end
            check($sformatf("fair_tenure%0d", t), grant_o, (t % 2 == 1) ? 2'b10 : 2'b01);
            if (found) begin
                n = grant_o[1] ? 1 : 0;
                tick();
                m_cyc_i[n] = 1'b0;
                tick();
                m_cyc_i = 2'b11;
            end
        end

        // Watchdog: no slave response, err injected on the 5th strobe cycle.
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        #4;
        check("wd_idle_grant", grant_o, 2'b00);
        tick();
        for (int i = 1; i <= 6; i++) begin
            #4;
            check($sformatf("wd_grant_c%0d", i), grant_o, 2'b01);
            check($sformatf("wd_s_stb_c%0d", i), s_stb_o, (i == 5) ? 1'b0 : 1'b1);
            check($sformatf("wd_m_err_c%0d", i), m_err_o, (i == 5) ? 2'b01 : 2'b00);
            tick();
        end

        // Slave ack on the timeout cycle wins over the injected err.
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        for (int i = 1; i <= 6; i++) begin
            s_ack_i = (i == 5);
            #4;
            check($sformatf("wdack_m_err_c%0d", i), m_err_o, 2'b00);
            check($sformatf("wdack_m_ack_c%0d", i), m_ack_o, (i == 5) ? 2'b01 : 2'b00);
            check($sformatf("wdack_s_stb_c%0d", i), s_stb_o, 1'b1);
            tick();
        end
        s_ack_i = 1'b0;

        // Asynchronous reset mid-tenure, then arbitration restarts from master 0.
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        #2;
        check("arst_pre_grant", grant_o, 2'b01);
        rst_n = 1'b0;
        s_ack_i = 1'b1;
        #1;
        check("arst_grant", grant_o, 2'b00);
        check("arst_s_cyc", s_cyc_o, 1'b0);
        check("arst_s_stb", s_stb_o, 1'b0);
        check("arst_m_ack", m_ack_o, 2'b00);
        #1;
        rst_n = 1'b1;
        s_ack_i = 1'b0;
        m_cyc_i = 2'b11; m_stb_i = 2'b00;
        tick();
        #4;
        check("arst_rr_restart", grant_o, 2'b01);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 9) == 0) m_cyc_i[k] = ~m_cyc_i[k];
                m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 7) != 0);
                m_we_i[k]  = 1'($urandom_range(0, 1));
            end
            m_adr_i = {$urandom, $urandom};
            m_dat_i = {$urandom, $urandom};
            m_sel_i = 8'($urandom);
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(0, 3) == 0);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_rty_i = ($urandom_range(0, 15) == 0);
            #4;
            mdl_eval();
            check("rnd_grant", grant_o, e_grant);
            check("rnd_s_cyc", s_cyc_o, e_cyc);
            check("rnd_s_stb", s_stb_o, e_stb);
            check("rnd_s_we", s_we_o, e_we);
            check("rnd_s_adr", s_adr_o, e_adr);
            check("rnd_s_dat", s_dat_o, e_dat);
            check("rnd_s_sel", s_sel_o, e_sel);
            check("rnd_m_ack", m_ack_o, e_ack);
            check("rnd_m_err", m_err_o, e_err);
            check("rnd_m_rty", m_rty_o, e_rty);
            check("rnd_m_dat", m_dat_o, s_dat_i);
            mdl_advance();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
